adder_rr_arbiter: RTL and testbench

- Shares one registered W-bit adder (sum plus carry-out) between N_REQ requesters, using a round-robin arbiter with valid/ready handshakes on both sides.
- Sits between the pin-level input decode and uo_out. Several requester slots, e.g. ui_in/uio_in pairs captured by upstream logic, contend for the single adder.
- Provides a registered result port tagged with the requester id, plus a wrap-around completion counter.

---
 rtl/adder_arb_pkg.sv | 40 ++++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/adder_rr_arbiter.sv | 98 +++++++++
 tb/tb_adder_rr_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// ============================================================================
// adder_arb_pkg : shared constants and round-robin pick helper
// Rev 1.0
// ============================================================================
`default_nettype none

package adder_arb_pkg;

  localparam int C_N_REQ_DEF = 4;
  localparam int C_W_DEF     = 8;
  localparam int C_N_MAX     = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Scans offsets from the top down so the smallest offset from ptr wins.
  function automatic rr_pick_t rr_pick(input logic [7:0] valid,
                                       input logic [2:0] ptr,
                                       input int         n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = C_N_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (valid[j[2:0]]) begin
          r.found = 1'b1;
          r.idx   = j[2:0];
        end
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick over N_REQ requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = C_N_REQ_DEF,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic             i_en,
  input  logic [N_REQ-1:0] i_valid,
  input  logic [IDW-1:0]   i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_found,
  output logic [IDW-1:0]   o_idx
);

  logic [7:0] w_valid_ext;
  logic [2:0] w_ptr_ext;
  rr_pick_t   w_pick;

  always_comb begin
    w_valid_ext               = '0;
    w_valid_ext[N_REQ-1:0]    = i_valid;
    w_ptr_ext                 = '0;
    w_ptr_ext[IDW-1:0]        = i_ptr;
  end

  assign w_pick  = rr_pick(w_valid_ext, w_ptr_ext, N_REQ);
  assign o_found = i_en && w_pick.found;
  assign o_idx   = w_pick.idx[IDW-1:0];

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      o_grant[i] = o_found && (w_pick.idx == 3'(i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/adder_rr_arbiter.sv
// ============================================================================
// adder_rr_arbiter : one registered W-bit adder shared round-robin by N_REQ
// requesters, with id-tagged result and a completion counter.  Rev 1.0
// ============================================================================
`default_nettype none

module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = C_N_REQ_DEF,
  parameter int W     = C_W_DEF,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W-1:0]       res_sum,
  output logic               res_carry,
  output logic [IDW-1:0]     res_id,
  output logic [7:0]         op_count
);

  logic [IDW-1:0] r_ptr;
  logic           r_res_valid;
  logic [W-1:0]   r_res_sum;
  logic           r_res_carry;
  logic [IDW-1:0] r_res_id;
  logic [7:0]     r_op_count;

  logic             w_slot_free;
  logic             w_grant_en;
  logic             w_found;
  logic             w_drain;
  logic [N_REQ-1:0] w_grant;
  logic [IDW-1:0]   w_idx;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [W:0]       w_sum;

  // The slot may be refilled in the same cycle it drains; rst_n keeps
  // req_ready quiet while reset is held.
  assign w_slot_free = !r_res_valid || res_ready;
  assign w_grant_en  = rst_n && ena && w_slot_free;
  assign w_drain     = r_res_valid && res_ready;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .i_en    (w_grant_en),
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign req_ready = w_grant;
  assign w_a       = req_a[int'(w_idx)*W +: W];
  assign w_b       = req_b[int'(w_idx)*W +: W];
  assign w_sum     = {1'b0, w_a} + {1'b0, w_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_carry <= 1'b0;
      r_res_id    <= '0;
      r_op_count  <= '0;
    end else begin
      if (w_drain) r_op_count <= r_op_count + 8'd1;
      if (w_found) begin
        r_res_valid <= 1'b1;
        r_res_sum   <= w_sum[W-1:0];
        r_res_carry <= w_sum[W];
        r_res_id    <= w_idx;
        r_ptr       <= (w_idx == IDW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
      end else if (w_drain) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_sum   = r_res_sum;
  assign res_carry = r_res_carry;
  assign res_id    = r_res_id;
  assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_adder_rr_arbiter.sv
// ============================================================================
// tb_adder_rr_arbiter : directed and randomized checks of adder_rr_arbiter
// against a transaction-level reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_adder_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_carry;
  logic [1:0]   res_id;
  logic [7:0]   op_count;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  int       m_ptr;
  bit       m_valid;
  bit [7:0] m_sum;
  bit       m_carry;
  int       m_id;
  bit [7:0] m_cnt;
  logic [N-1:0] g_last;

  always #5 clk = ~clk;

  adder_rr_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_id    (res_id),
    .op_count  (op_count)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_sum = 0; m_carry = 0; m_id = 0; m_cnt = 0;
  endtask

  // Winner = valid requester at the smallest circular distance from ptr.
  function automatic logic [N-1:0] exp_grant();
    int best, bestd, d;
    if (!rst_n || !ena || (m_valid && !res_ready) || req_valid == '0) return '0;
    best = 0; bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i - m_ptr + N) % N;
      if (req_valid[i] && d < bestd) begin best = i; bestd = d; end
    end
    return N'(1) << best;
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*W +: W] = 8'(a);
    req_b[i*W +: W] = 8'(b);
  endtask

  // Called right after a falling edge with inputs already driven.
  task automatic step();
    logic [N-1:0] g;
    int s;
    #1;
    g = exp_grant();
    g_last = g;
    chk_eq("req_ready", 32'(req_ready), 32'(g));
    @(posedge clk);
    if (m_valid && res_ready) m_cnt = m_cnt + 8'd1;
    if (g != '0) begin
      for (int i = 0; i < N; i++) if (g[i]) begin
        s = int'(req_a[i*W +: W]) + int'(req_b[i*W +: W]);
        m_sum = 8'(s % 256); m_carry = (s >= 256); m_id = i;
        m_valid = 1; m_ptr = (i + 1) % N;
      end
    end else if (m_valid && res_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
    chk_eq("res_valid", 32'(res_valid), 32'(m_valid));
    chk_eq("res_sumc",  32'({res_carry, res_sum}), 32'({m_carry, m_sum}));
    chk_eq("res_id",    32'(res_id), 32'(m_id));
    chk_eq("op_count",  32'(op_count), 32'(m_cnt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; req_valid = '0; res_ready = 1'b1;
    req_a = '0; req_b = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; req_valid = '0; res_ready = 1'b0;
    req_a = '0; req_b = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk_eq("rst_valid", 32'(res_valid), 0);
    chk_eq("rst_ready", 32'(req_ready), 0);
    rst_n = 1'b1;

    // Asynchronous reset with a pending result
    ena = 1'b1; res_ready = 1'b0; req_valid = 4'b0100; set_op(2, 9, 9);
    step();
    chk_eq("pre_rst_valid", 32'(res_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_valid", 32'(res_valid), 0);
    chk_eq("arst_sumc",  32'({res_carry, res_sum}), 0);
    chk_eq("arst_cnt",   32'(op_count), 0);
    chk_eq("arst_ready", 32'(req_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; res_ready = 1'b1; req_valid = 4'b0001; set_op(0, 3, 4);
    step();
    chk_eq("post_rst_sum", 32'({res_carry, res_sum}), 7);
    chk_eq("post_rst_id",  32'(res_id), 0);

    // Round-robin fairness, all requesters valid
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_op(i, i, 10 * i);
    for (int k = 0; k < 8; k++) begin
      step();
      chk_eq("rr_id",  32'(res_id), 32'(k % N));
      chk_eq("rr_sum", 32'(res_sum), 32'(11 * (k % N)));
    end

    // Back-pressure, then same-cycle refill
    do_reset();
    req_valid = 4'b0010; set_op(1, 8'h80, 8'h90);
    step();
    chk_eq("bp_sumc", 32'({res_carry, res_sum}), 32'h110);
    res_ready = 1'b0; req_valid = 4'b0110; set_op(2, 5, 6);
    repeat (3) step();
    chk_eq("bp_hold", 32'({res_carry, res_sum}), 32'h110);
    res_ready = 1'b1;
    step();
    chk_eq("bp_refill_id", 32'(res_id), 2);

    // Pointer skip across idle cycles
    do_reset();
    req_valid = 4'b0010; step();
    req_valid = 4'b0000; repeat (2) step();
    req_valid = 4'b0011; set_op(0, 1, 2); set_op(1, 3, 3);
    step();
    chk_eq("skip_id0", 32'(res_id), 0);
    req_valid = 4'b0010;
    step();
    chk_eq("skip_id1", 32'(res_id), 1);

    // ena gating with a pending result
    do_reset();
    res_ready = 1'b0; req_valid = 4'b0001; step();
    ena = 1'b0; res_ready = 1'b1; req_valid = 4'b0100; set_op(2, 20, 22);
    step();
    chk_eq("ena_drained", 32'(res_valid), 0);
    step();
    ena = 1'b1;
    step();
    chk_eq("ena_id", 32'(res_id), 2);
    chk_eq("ena_sum", 32'(res_sum), 42);

    // Counter wrap after 256 consumed results, plus max-operand overflow
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_op(i, 8'hFF, 8'hFF);
    repeat (257) step();
    chk_eq("wrap_cnt",  32'(op_count), 0);
    chk_eq("wrap_sumc", 32'({res_carry, res_sum}), 32'h1FE);

    // Randomized traffic; requesters hold until accepted
    do_reset();
    for (int k = 0; k < 400; k++) begin
      ena       = ($urandom_range(0, 9) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      step();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || g_last[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
